axi4_xbar: RTL and testbench
============================

AXI4_XBAR -- requirements
Module: axi4_xbar

Interface
REQ-001 SHALL have parameter S0_BASE, default 32'h8000_0000, base address of slave port 0 (main memory).
REQ-002 SHALL have parameter S0_MASK, default 32'hF800_0000, address bits compared for slave port 0.
REQ-003 SHALL have parameter S1_BASE, default 32'h1000_0000, base address of slave port 1 (UART/CLINT peripherals).
REQ-004 SHALL have parameter S1_MASK, default 32'hFFFF_F000, address bits compared for slave port 1.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port m  axi4_interface.slave  -  upstream port, driven by the arbiter's downstream master port; addr/data 32, id 4, len 8, size 3, burst 2.
REQ-008 SHALL have port s0  axi4_interface.master  -  downstream port to memory.
REQ-009 SHALL have port s1  axi4_interface.master  -  downstream port to peripherals.

Function
REQ-010 Decode: target = s0 if (addr & S0_MASK) == S0_BASE, else s1 if (addr & S1_MASK) == S1_BASE, else DECERR; s0 wins on overlap.
REQ-011 Read FSM states: R_IDLE, R_ADDR, R_DATA, R_ERR.
REQ-012 R_IDLE: m.arready=0; on m.arvalid, latch target, arid and arlen, then go to R_ADDR (valid target) or R_ERR (no target).
REQ-013 R_ADDR: forward all m.ar* signals to the selected port only; m.arready = selected arready; on arvalid&arready go to R_DATA.
REQ-014 R_DATA: forward r* from the selected port to m and m.rready to the selected port; on rvalid&rready&rlast go to R_IDLE.
REQ-015 R_ERR: first raise m.arready for 1 cycle to accept the address; then return arlen+1 beats with rresp=2'b11, rdata=0, rid=latched arid, and rlast on the final beat; go to R_IDLE after the last beat completes.
REQ-016 Write FSM states: W_IDLE, W_XFER, W_RESP, W_ERR, W_ERRB.
REQ-017 W_IDLE: on m.awvalid, latch target and awid, then go to W_XFER (valid target) or W_ERR (no target); m.wvalid alone SHALL NOT start a transaction.
REQ-018 W_XFER: route aw* and w* to the selected port; track AW and final-W completion with separate done flags (these handshakes can complete in either order or the same cycle); hold awvalid low after the AW handshake; go to W_RESP once both are done.
REQ-019 W_RESP: forward b* to m; on bvalid&bready go to W_IDLE.
REQ-020 W_ERR: accept the AW handshake and all W beats through wlast, discarding the data; then W_ERRB drives bvalid=1, bresp=2'b11, bid=latched awid until bready, then goes to W_IDLE.
REQ-021 Unselected ports and idle states SHALL drive all valid/ready outputs to 0 and data outputs to 0.
REQ-022 Read and write FSMs SHALL be independent; a read and a write to different or the same targets MAY be in flight simultaneously.
REQ-023 Combinational paths from downstream ready to upstream ready are permitted; the block adds no latency beyond one R_IDLE/W_IDLE decode cycle per transaction.

Reset
REQ-024 On rst, both FSMs SHALL enter IDLE, latched target/id/len/beat counter SHALL clear to 0, and all valid/ready outputs on m, s0 and s1 SHALL be 0 the following cycle.
REQ-025 Reset mid-transaction SHALL abandon the transaction; no response is owed.

Structure
REQ-026 SHALL place the FSM state enums, the target encoding (T_S0, T_S1, T_ERR) and RESP_DECERR=2'b11 in the shared package axi4_pkg.
REQ-027 SHALL implement decoding in sub-module axi4_addr_decode (addr in, 2-bit target out), instantiated once for AR and once for AW.

Verification
REQ-028 Read 0x8000_0010 with arlen=0 while s0 returns 0xDEADBEEF -> m sees rdata=0xDEADBEEF, rresp=0, rlast=1, and s1.arvalid stays 0.
REQ-029 Write 0x1000_0000 data 0x41 with wstrb=4'h1, issuing W one cycle before AW -> s1 receives both, m gets bresp=0, and s0 sees no activity.
REQ-030 Read 0x0000_0004 with arlen=3 and arid=5 -> 4 beats with rresp=2'b11 and rid=5, rlast on beat 4 only.
REQ-031 Write to 0x2000_0000 with awlen=1 -> 2 W beats accepted, then bresp=2'b11; no downstream valid asserted.
REQ-032 Concurrent read from s0 and write to s1, with rready held low 3 cycles -> both complete; rdata stable while stalled.
REQ-033 Assert rst during R_DATA -> next cycle all valids are 0 and the read FSM is in R_IDLE; a new read then completes normally.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared types for the AXI4 interconnect: bus widths, decode targets,
// response codes and the crossbar FSM state encodings.
package axi4_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int ID_W   = 4;

   localparam logic [1:0] T_S0  = 2'd0;
   localparam logic [1:0] T_S1  = 2'd1;
   localparam logic [1:0] T_ERR = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rd_state_e;
   typedef enum logic [2:0] {W_IDLE, W_XFER, W_RESP, W_ERR, W_ERRB} wr_state_e;
endpackage

// File: rtl/axi4_interface.sv
// AXI4 bundle (32-bit addr/data, 4-bit id) with master and slave views.
interface axi4_interface;
   import axi4_pkg::*;

   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awvalid, awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast, wvalid, wready;
   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid, bready;
   logic [ID_W-1:0]     arid;
   logic [ADDR_W-1:0]   araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arvalid, arready;
   logic [ID_W-1:0]     rid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast, rvalid, rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input bid, bresp, bvalid, output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
      input rid, rdata, rresp, rlast, rvalid, output rready
   );

   modport slave (
      input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
      input wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready,
      input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready
   );
endinterface

// File: rtl/axi4_addr_decode.sv
// Address decoder: memory window first, then peripheral window, else DECERR.
module axi4_addr_decode
   import axi4_pkg::*;
#(
   parameter logic [31:0] S0_BASE = 32'h8000_0000,
   parameter logic [31:0] S0_MASK = 32'hF800_0000,
   parameter logic [31:0] S1_BASE = 32'h1000_0000,
   parameter logic [31:0] S1_MASK = 32'hFFFF_F000
) (
   input  logic [31:0] addr,
   output logic [1:0]  target
);
   always_comb begin
      if ((addr & S0_MASK) == S0_BASE)      target = T_S0;
      else if ((addr & S1_MASK) == S1_BASE) target = T_S1;
      else                                  target = T_ERR;
   end
endmodule

// File: rtl/axi4_xbar.sv
// 1-to-2 AXI4 crossbar: independent read and write FSMs route each burst to
// memory (s0) or peripherals (s1); unmapped addresses get a local DECERR.
module axi4_xbar
   import axi4_pkg::*;
#(
   parameter logic [31:0] S0_BASE = 32'h8000_0000,
   parameter logic [31:0] S0_MASK = 32'hF800_0000,
   parameter logic [31:0] S1_BASE = 32'h1000_0000,
   parameter logic [31:0] S1_MASK = 32'hFFFF_F000
) (
   input  logic          clk,
   input  logic          rst,
   axi4_interface.slave  m,
   axi4_interface.master s0,
   axi4_interface.master s1
);
   rd_state_e       r_state, r_nxt;
   wr_state_e       w_state, w_nxt;
   logic [1:0]      ar_tgt, aw_tgt, r_tgt, w_tgt;
   logic [ID_W-1:0] r_id, w_id;
   logic [7:0]      r_len, r_cnt;
   logic            r_ar_ok, aw_done, w_done, aw_hs, wl_hs;
   logic            sel_arready, sel_rvalid, sel_rlast, sel_awready, sel_wready, sel_bvalid;

   axi4_addr_decode #(.S0_BASE(S0_BASE), .S0_MASK(S0_MASK), .S1_BASE(S1_BASE), .S1_MASK(S1_MASK))
      u_ar_dec (.addr(m.araddr), .target(ar_tgt));
   axi4_addr_decode #(.S0_BASE(S0_BASE), .S0_MASK(S0_MASK), .S1_BASE(S1_BASE), .S1_MASK(S1_MASK))
      u_aw_dec (.addr(m.awaddr), .target(aw_tgt));

   assign sel_arready = (r_tgt == T_S1) ? s1.arready : s0.arready;
   assign sel_rvalid  = (r_tgt == T_S1) ? s1.rvalid  : s0.rvalid;
   assign sel_rlast   = (r_tgt == T_S1) ? s1.rlast   : s0.rlast;
   assign sel_awready = (w_tgt == T_S1) ? s1.awready : s0.awready;
   assign sel_wready  = (w_tgt == T_S1) ? s1.wready  : s0.wready;
   assign sel_bvalid  = (w_tgt == T_S1) ? s1.bvalid  : s0.bvalid;

   // ---------------- read channel ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= R_IDLE; r_tgt <= T_S0; r_id <= '0; r_len <= '0; r_cnt <= '0; r_ar_ok <= 1'b0;
      end else begin
         r_state <= r_nxt;
         if (r_state == R_IDLE) begin
            if (m.arvalid) begin r_tgt <= ar_tgt; r_id <= m.arid; r_len <= m.arlen; end
            r_cnt   <= '0;
            r_ar_ok <= 1'b0;
         end else if (r_state == R_ERR) begin
            if (!r_ar_ok)     r_ar_ok <= m.arvalid;
            else if (m.rready) r_cnt  <= r_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      r_nxt = r_state;
      m.arready = 1'b0;
      m.rvalid = 1'b0; m.rid = '0; m.rdata = '0; m.rresp = '0; m.rlast = 1'b0;
      s0.arvalid = 1'b0; s0.arid = '0; s0.araddr = '0; s0.arlen = '0; s0.arsize = '0; s0.arburst = '0;
      s1.arvalid = 1'b0; s1.arid = '0; s1.araddr = '0; s1.arlen = '0; s1.arsize = '0; s1.arburst = '0;
      s0.rready = 1'b0; s1.rready = 1'b0;
      case (r_state)
         R_IDLE: if (m.arvalid) r_nxt = (ar_tgt == T_ERR) ? R_ERR : R_ADDR;
         R_ADDR: begin
            if (r_tgt == T_S1) begin
               s1.arvalid = m.arvalid; s1.arid = m.arid; s1.araddr = m.araddr;
               s1.arlen = m.arlen; s1.arsize = m.arsize; s1.arburst = m.arburst;
            end else begin
               s0.arvalid = m.arvalid; s0.arid = m.arid; s0.araddr = m.araddr;
               s0.arlen = m.arlen; s0.arsize = m.arsize; s0.arburst = m.arburst;
            end
            m.arready = sel_arready;
            if (m.arvalid && sel_arready) r_nxt = R_DATA;
         end
         R_DATA: begin
            if (r_tgt == T_S1) begin
               m.rvalid = s1.rvalid; m.rid = s1.rid; m.rdata = s1.rdata; m.rresp = s1.rresp; m.rlast = s1.rlast;
               s1.rready = m.rready;
            end else begin
               m.rvalid = s0.rvalid; m.rid = s0.rid; m.rdata = s0.rdata; m.rresp = s0.rresp; m.rlast = s0.rlast;
               s0.rready = m.rready;
            end
            if (sel_rvalid && m.rready && sel_rlast) r_nxt = R_IDLE;
         end
         R_ERR: begin
            // One cycle of arready swallows the address, then the error beats follow.
            if (!r_ar_ok) begin
               m.arready = 1'b1;
            end else begin
               m.rvalid = 1'b1; m.rid = r_id; m.rresp = RESP_DECERR; m.rlast = (r_cnt == r_len);
               if (m.rready && (r_cnt == r_len)) r_nxt = R_IDLE;
            end
         end
         default: r_nxt = R_IDLE;
      endcase
   end

   // ---------------- write channel ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state <= W_IDLE; w_tgt <= T_S0; w_id <= '0; aw_done <= 1'b0; w_done <= 1'b0;
      end else begin
         w_state <= w_nxt;
         if (w_state == W_IDLE) begin
            if (m.awvalid) begin w_tgt <= aw_tgt; w_id <= m.awid; end
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (wl_hs) w_done  <= 1'b1;
         end
      end
   end

   always_comb begin
      w_nxt = w_state; aw_hs = 1'b0; wl_hs = 1'b0;
      m.awready = 1'b0; m.wready = 1'b0; m.bvalid = 1'b0; m.bid = '0; m.bresp = '0;
      s0.awvalid = 1'b0; s0.awid = '0; s0.awaddr = '0; s0.awlen = '0; s0.awsize = '0; s0.awburst = '0;
      s1.awvalid = 1'b0; s1.awid = '0; s1.awaddr = '0; s1.awlen = '0; s1.awsize = '0; s1.awburst = '0;
      s0.wvalid = 1'b0; s0.wdata = '0; s0.wstrb = '0; s0.wlast = 1'b0; s0.bready = 1'b0;
      s1.wvalid = 1'b0; s1.wdata = '0; s1.wstrb = '0; s1.wlast = 1'b0; s1.bready = 1'b0;
      case (w_state)
         W_IDLE: if (m.awvalid) w_nxt = (aw_tgt == T_ERR) ? W_ERR : W_XFER;
         W_XFER: begin
            // AW and the last W may finish in any order; each is masked once done.
            if (w_tgt == T_S1) begin
               s1.awvalid = m.awvalid & ~aw_done; s1.awid = m.awid; s1.awaddr = m.awaddr;
               s1.awlen = m.awlen; s1.awsize = m.awsize; s1.awburst = m.awburst;
               s1.wvalid = m.wvalid & ~w_done; s1.wdata = m.wdata; s1.wstrb = m.wstrb; s1.wlast = m.wlast;
            end else begin
               s0.awvalid = m.awvalid & ~aw_done; s0.awid = m.awid; s0.awaddr = m.awaddr;
               s0.awlen = m.awlen; s0.awsize = m.awsize; s0.awburst = m.awburst;
               s0.wvalid = m.wvalid & ~w_done; s0.wdata = m.wdata; s0.wstrb = m.wstrb; s0.wlast = m.wlast;
            end
            m.awready = sel_awready & ~aw_done;
            m.wready  = sel_wready & ~w_done;
            aw_hs = m.awvalid & sel_awready & ~aw_done;
            wl_hs = m.wvalid & sel_wready & m.wlast & ~w_done;
            if ((aw_done || aw_hs) && (w_done || wl_hs)) w_nxt = W_RESP;
         end
         W_RESP: begin
            if (w_tgt == T_S1) begin
               m.bvalid = s1.bvalid; m.bid = s1.bid; m.bresp = s1.bresp; s1.bready = m.bready;
            end else begin
               m.bvalid = s0.bvalid; m.bid = s0.bid; m.bresp = s0.bresp; s0.bready = m.bready;
            end
            if (sel_bvalid && m.bready) w_nxt = W_IDLE;
         end
         W_ERR: begin
            m.awready = ~aw_done;
            m.wready  = ~w_done;
            aw_hs = m.awvalid & ~aw_done;
            wl_hs = m.wvalid & m.wlast & ~w_done;
            if ((aw_done || aw_hs) && (w_done || wl_hs)) w_nxt = W_ERRB;
         end
         W_ERRB: begin
            m.bvalid = 1'b1; m.bid = w_id; m.bresp = RESP_DECERR;
            if (m.bready) w_nxt = W_IDLE;
         end
         default: w_nxt = W_IDLE;
      endcase
   end
endmodule

// File: tb/tb_axi4_xbar.sv
// Directed bench for axi4_xbar: expected R/B responses go into queues and a
// negedge monitor pops and compares them as the crossbar presents them.
module tb_axi4_xbar;
   import axi4_pkg::*;

   typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} rexp_t;
   typedef struct packed {logic [3:0] id; logic [1:0] resp;} bexp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi4_interface m_if ();
   axi4_interface s0_if ();
   axi4_interface s1_if ();

   axi4_xbar dut (.clk(clk), .rst(rst), .m(m_if), .s0(s0_if), .s1(s1_if));

   rexp_t       exp_r[$];
   bexp_t       exp_b[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          s0_act = 0, s1_act = 0, m_wbeats = 0;
   logic [31:0] s0_data = 32'h0;
   logic [31:0] s1_awaddr = 32'h0, s1_wdata = 32'h0;
   logic [3:0]  s1_wstrb = 4'h0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [14:0] valids();
      return {m_if.arready, m_if.awready, m_if.wready, m_if.rvalid, m_if.bvalid,
              s0_if.arvalid, s0_if.awvalid, s0_if.wvalid, s0_if.rready, s0_if.bready,
              s1_if.arvalid, s1_if.awvalid, s1_if.wvalid, s1_if.rready, s1_if.bready};
   endfunction

   task automatic push_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp, input logic last);
      rexp_t e;
      e.id = id; e.data = d; e.resp = resp; e.last = last;
      exp_r.push_back(e);
   endtask

   task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
      bexp_t e;
      e.id = id; e.resp = resp;
      exp_b.push_back(e);
   endtask

   // monitor: scoreboard pops plus activity counters
   initial begin : monitor
      rexp_t er, ar;
      bexp_t eb, ab;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (s0_if.arvalid || s0_if.awvalid || s0_if.wvalid) s0_act++;
            if (s1_if.arvalid || s1_if.awvalid || s1_if.wvalid) s1_act++;
            if (m_if.wvalid && m_if.wready) m_wbeats++;
            if (m_if.rvalid && m_if.rready) begin
               ar.id = m_if.rid; ar.data = m_if.rdata; ar.resp = m_if.rresp; ar.last = m_if.rlast;
               n_tests++;
               if (exp_r.size() == 0) begin
                  n_fail++;
                  $display("FAIL r_unexpected got id=%0h data=%h resp=%0h last=%0b exp none", ar.id, ar.data, ar.resp, ar.last);
               end else begin
                  er = exp_r.pop_front();
                  if (ar !== er) begin
                     n_fail++;
                     $display("FAIL r_beat got id=%0h data=%h resp=%0h last=%0b exp id=%0h data=%h resp=%0h last=%0b",
                              ar.id, ar.data, ar.resp, ar.last, er.id, er.data, er.resp, er.last);
                  end
               end
            end else if (m_if.rvalid && exp_r.size() > 0) begin
               n_tests++;
               if (m_if.rdata !== exp_r[0].data) begin
                  n_fail++;
                  $display("FAIL r_stall_data got=%h exp=%h", m_if.rdata, exp_r[0].data);
               end
            end
            if (m_if.bvalid && m_if.bready) begin
               ab.id = m_if.bid; ab.resp = m_if.bresp;
               n_tests++;
               if (exp_b.size() == 0) begin
                  n_fail++;
                  $display("FAIL b_unexpected got id=%0h resp=%0h exp none", ab.id, ab.resp);
               end else begin
                  eb = exp_b.pop_front();
                  if (ab !== eb) begin
                     n_fail++;
                     $display("FAIL b_resp got id=%0h resp=%0h exp id=%0h resp=%0h", ab.id, ab.resp, eb.id, eb.resp);
                  end
               end
            end
         end
      end
   end

   // s0: memory read responder, rdata = s0_data + beat index
   initial begin : s0_slave
      logic rs, ar_hs, r_hs;
      logic [7:0] len;
      logic [3:0] id;
      int beats, cur;
      s0_if.awready = 1'b0; s0_if.wready = 1'b0; s0_if.bvalid = 1'b0; s0_if.bid = '0; s0_if.bresp = '0;
      s0_if.arready = 1'b1; s0_if.rvalid = 1'b0; s0_if.rid = '0; s0_if.rdata = '0; s0_if.rresp = '0; s0_if.rlast = 1'b0;
      beats = 0; cur = 0;
      forever begin
         @(negedge clk);
         rs = rst; ar_hs = s0_if.arvalid && s0_if.arready; r_hs = s0_if.rvalid && s0_if.rready;
         len = s0_if.arlen; id = s0_if.arid;
         @(posedge clk); #1;
         if (rs) begin
            s0_if.arready = 1'b1; s0_if.rvalid = 1'b0; s0_if.rlast = 1'b0;
         end else if (ar_hs) begin
            s0_if.arready = 1'b0; beats = int'(len) + 1; cur = 0;
            s0_if.rvalid = 1'b1; s0_if.rid = id; s0_if.rdata = s0_data; s0_if.rresp = 2'b00;
            s0_if.rlast = (beats == 1);
         end else if (r_hs) begin
            cur++;
            if (cur == beats) begin
               s0_if.rvalid = 1'b0; s0_if.rlast = 1'b0; s0_if.arready = 1'b1;
            end else begin
               s0_if.rdata = s0_data + 32'(cur); s0_if.rlast = (cur == beats - 1);
            end
         end
      end
   end

   // s1: peripheral write responder, records the last address/data/strobe seen
   initial begin : s1_slave
      logic rs, aw_hs, w_hs, wl, b_hs, got_aw, got_wl;
      logic [3:0] id, bid_l, st;
      logic [31:0] a, d;
      s1_if.arready = 1'b0; s1_if.rvalid = 1'b0; s1_if.rid = '0; s1_if.rdata = '0; s1_if.rresp = '0; s1_if.rlast = 1'b0;
      s1_if.awready = 1'b1; s1_if.wready = 1'b1; s1_if.bvalid = 1'b0; s1_if.bid = '0; s1_if.bresp = '0;
      got_aw = 1'b0; got_wl = 1'b0; bid_l = '0;
      forever begin
         @(negedge clk);
         rs = rst; aw_hs = s1_if.awvalid && s1_if.awready; w_hs = s1_if.wvalid && s1_if.wready;
         wl = s1_if.wlast; b_hs = s1_if.bvalid && s1_if.bready;
         id = s1_if.awid; a = s1_if.awaddr; d = s1_if.wdata; st = s1_if.wstrb;
         @(posedge clk); #1;
         if (rs) begin
            s1_if.bvalid = 1'b0; got_aw = 1'b0; got_wl = 1'b0;
         end else begin
            if (aw_hs) begin got_aw = 1'b1; s1_awaddr = a; bid_l = id; end
            if (w_hs) begin s1_wdata = d; s1_wstrb = st; if (wl) got_wl = 1'b1; end
            if (b_hs) begin
               s1_if.bvalid = 1'b0; got_aw = 1'b0; got_wl = 1'b0;
            end else if (got_aw && got_wl && !s1_if.bvalid) begin
               s1_if.bvalid = 1'b1; s1_if.bid = bid_l; s1_if.bresp = 2'b00;
            end
         end
      end
   end

   task automatic ar_issue(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
      int n = 0;
      logic done = 1'b0;
      m_if.arvalid = 1'b1; m_if.araddr = a; m_if.arid = id; m_if.arlen = len;
      m_if.arsize = 3'd2; m_if.arburst = 2'b01;
      while (!done && n < 50) begin
         @(negedge clk); done = m_if.arready;
         @(posedge clk); #1; n++;
      end
      if (!done) begin n_tests++; n_fail++; $display("FAIL ar_timeout addr=%h got no arready exp arready", a); end
      m_if.arvalid = 1'b0; m_if.araddr = '0;
   endtask

   task automatic aw_issue(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
      int n = 0;
      logic done = 1'b0;
      m_if.awvalid = 1'b1; m_if.awaddr = a; m_if.awid = id; m_if.awlen = len;
      m_if.awsize = 3'd2; m_if.awburst = 2'b01;
      while (!done && n < 50) begin
         @(negedge clk); done = m_if.awready;
         @(posedge clk); #1; n++;
      end
      if (!done) begin n_tests++; n_fail++; $display("FAIL aw_timeout addr=%h got no awready exp awready", a); end
      m_if.awvalid = 1'b0; m_if.awaddr = '0;
   endtask

   task automatic w_issue(input logic [31:0] d, input logic [3:0] strb, input int beats);
      for (int b = 0; b < beats; b++) begin
         int n = 0;
         logic done = 1'b0;
         m_if.wvalid = 1'b1; m_if.wdata = d + 32'(b); m_if.wstrb = strb; m_if.wlast = (b == beats - 1);
         while (!done && n < 50) begin
            @(negedge clk); done = m_if.wready;
            @(posedge clk); #1; n++;
         end
         if (!done) begin n_tests++; n_fail++; $display("FAIL w_timeout beat=%0d got no wready exp wready", b); end
      end
      m_if.wvalid = 1'b0; m_if.wlast = 1'b0;
   endtask

   task automatic wait_rvalid(input string name);
      int n = 0;
      while (!m_if.rvalid && n < 100) begin @(negedge clk); n++; end
      if (!m_if.rvalid) begin n_tests++; n_fail++; $display("FAIL %s_rvalid_timeout got 0 exp 1", name); end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 200) begin @(posedge clk); #1; n++; end
      n_tests++;
      if (exp_r.size() != 0 || exp_b.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain got r_left=%0d b_left=%0d exp 0", name, exp_r.size(), exp_b.size());
         exp_r.delete(); exp_b.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin : main
      m_if.awvalid = 1'b0; m_if.awaddr = '0; m_if.awid = '0; m_if.awlen = '0; m_if.awsize = '0; m_if.awburst = '0;
      m_if.wvalid = 1'b0; m_if.wdata = '0; m_if.wstrb = '0; m_if.wlast = 1'b0; m_if.bready = 1'b1;
      m_if.arvalid = 1'b0; m_if.araddr = '0; m_if.arid = '0; m_if.arlen = '0; m_if.arsize = '0; m_if.arburst = '0;
      m_if.rready = 1'b1;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valids", 64'(valids()), 64'h0);
      chk("reset_rstate", 64'(dut.r_state), 64'(R_IDLE));
      chk("reset_wstate", 64'(dut.w_state), 64'(W_IDLE));
      rst = 1'b0;
      @(posedge clk); #1;

      // single-beat read from memory
      s0_data = 32'hDEAD_BEEF; s1_act = 0;
      push_r(4'd2, 32'hDEAD_BEEF, 2'b00, 1'b1);
      ar_issue(32'h8000_0010, 4'd2, 8'd0);
      drain("rd_s0");
      chk("rd_s0_s1_quiet", 64'(s1_act), 64'd0);

      // peripheral write, W presented one cycle ahead of AW
      s0_act = 0;
      push_b(4'd3, 2'b00);
      fork
         w_issue(32'h0000_0041, 4'h1, 1);
         begin @(posedge clk); #1; aw_issue(32'h1000_0000, 4'd3, 8'd0); end
      join
      drain("wr_s1");
      chk("wr_s1_awaddr", 64'(s1_awaddr), 64'h1000_0000);
      chk("wr_s1_wdata", 64'(s1_wdata), 64'h41);
      chk("wr_s1_wstrb", 64'(s1_wstrb), 64'h1);
      chk("wr_s1_s0_quiet", 64'(s0_act), 64'd0);

      // unmapped read burst
      s0_act = 0; s1_act = 0;
      for (int i = 0; i < 4; i++) push_r(4'd5, 32'h0, 2'b11, i == 3);
      ar_issue(32'h0000_0004, 4'd5, 8'd3);
      drain("rd_err");
      chk("rd_err_quiet", 64'(s0_act + s1_act), 64'd0);

      // unmapped write burst
      s0_act = 0; s1_act = 0; m_wbeats = 0;
      push_b(4'd6, 2'b11);
      fork
         aw_issue(32'h2000_0000, 4'd6, 8'd1);
         w_issue(32'h0000_0011, 4'hF, 2);
      join
      drain("wr_err");
      chk("wr_err_wbeats", 64'(m_wbeats), 64'd2);
      chk("wr_err_quiet", 64'(s0_act + s1_act), 64'd0);

      // concurrent read (s0) and write (s1) with rready stalled 3 cycles
      s0_data = 32'h1234_0000; m_if.rready = 1'b0;
      push_r(4'd1, 32'h1234_0000, 2'b00, 1'b0);
      push_r(4'd1, 32'h1234_0001, 2'b00, 1'b1);
      push_b(4'd7, 2'b00);
      fork
         ar_issue(32'h8000_0100, 4'd1, 8'd1);
         aw_issue(32'h1000_0004, 4'd7, 8'd0);
         w_issue(32'h0000_0055, 4'hF, 1);
         begin
            wait_rvalid("conc");
            repeat (3) @(posedge clk);
            #1; m_if.rready = 1'b1;
         end
      join
      drain("conc");
      chk("conc_s1_wdata", 64'(s1_wdata), 64'h55);
      chk("conc_s1_awaddr", 64'(s1_awaddr), 64'h1000_0004);

      // reset while the read FSM sits in R_DATA
      s0_data = 32'hCAFE_0000; m_if.rready = 1'b0;
      ar_issue(32'h8000_0000, 4'd4, 8'd3);
      wait_rvalid("rst");
      chk("rst_pre_rstate", 64'(dut.r_state), 64'(R_DATA));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_valids", 64'(valids()), 64'h0);
      chk("rst_rstate", 64'(dut.r_state), 64'(R_IDLE));
      rst = 1'b0; m_if.rready = 1'b1;
      @(posedge clk); #1;
      push_r(4'd8, 32'hCAFE_0000, 2'b00, 1'b1);
      ar_issue(32'h8000_0040, 4'd8, 8'd0);
      drain("post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
